// File: rtl/obj_pkg.sv
// obj_pkg
//   Shared definitions for the proximity-sensor zone tracker.
//   - zone_width(n) : bits needed to index the 2*n zones of an n-sensor ring
//   - MAX_SENSORS   : largest ring the tracker is intended for
//   - evt_state_t   : state of the single-entry zone-change event register
package obj_pkg;

   localparam int MAX_SENSORS = 16;

   typedef enum logic {
      EVT_IDLE = 1'b0,
      EVT_PEND = 1'b1
   } evt_state_t;

   function automatic int zone_width(input int n);
      return $clog2(2 * n);
   endfunction

endpackage

// File: rtl/obj_debounce.sv
// obj_debounce
//   One raw sensor input: 2-flop synchroniser followed by a debounce filter.
//   The filtered value only follows the synchronised value after it has
//   differed for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   raw       in   asynchronous raw sensor input
//   filtered  out  debounced sensor level
module obj_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filtered
);

   logic       sync_a;
   logic       sync_b;
   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a   <= 1'b0;
         sync_b   <= 1'b0;
         count    <= 8'd0;
         filtered <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (sync_b == filtered) begin
            count <= 8'd0;
         end else if (count == 8'(DEBOUNCE_CYCLES - 1)) begin
            // This cycle is the DEBOUNCE_CYCLES-th consecutive difference.
            filtered <= sync_b;
            count    <= 8'd0;
         end else begin
            count <= count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/obj_zone_tracker.sv
// obj_zone_tracker
//   Ring of NUM_SENSORS proximity sensors (index 0 = front, clockwise).
//   Each sensor is synchronised and debounced, the filtered pattern is
//   classified into 2*NUM_SENSORS zones (single sensors and adjacent pairs),
//   the zone is published as a registered level and every change of
//   {zone_present, zone_idx} is queued in a single-entry valid/ready event
//   register.
//
//   Optional build macro OBJ_HOLD_EN: when defined, a zone lost because the
//   filtered pattern became empty is held for HOLD_CYCLES cycles; any legal
//   or ambiguous pattern cancels the hold at once.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   sensor_raw    in   [NUM_SENSORS]   raw asynchronous sensor inputs
//   zone_onehot   out  [2*NUM_SENSORS] bit 2i = sensor i, bit 2i+1 = i and i+1
//   zone_idx      out  [ZW]            index of the active zone, 0 if none
//   zone_present  out  exactly one legal zone active
//   ambiguous     out  nonzero pattern that is not a legal zone
//   evt_valid     out  zone-change event pending
//   evt_ready     in   consumer accepts the event
//   evt_zone_idx  out  [ZW] zone_idx captured at the change
//   evt_present   out  zone_present captured at the change
//   overflow      out  sticky: a pending event was overwritten
//   clr_overflow  in   clears overflow (a simultaneous overwrite wins)
module obj_zone_tracker
   import obj_pkg::*;
#(
   parameter  int NUM_SENSORS     = 4,
   parameter  int DEBOUNCE_CYCLES = 4,
   parameter  int HOLD_CYCLES     = 8,
   localparam int ZW              = zone_width(NUM_SENSORS),
   localparam int NZ              = 2 * NUM_SENSORS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SENSORS-1:0] sensor_raw,
   output logic [NZ-1:0]          zone_onehot,
   output logic [ZW-1:0]          zone_idx,
   output logic                   zone_present,
   output logic                   ambiguous,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [ZW-1:0]          evt_zone_idx,
   output logic                   evt_present,
   output logic                   overflow,
   input  logic                   clr_overflow
);

   // ------------------------------------------------------------------
   // Per-sensor synchroniser + debounce
   // ------------------------------------------------------------------
   logic [NUM_SENSORS-1:0] filt;

   generate
      for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
         obj_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .raw     (sensor_raw[gi]),
            .filtered(filt[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Classifier on the filtered vector
   // ------------------------------------------------------------------
   logic [4:0]    pop_count;
   logic [ZW-1:0] cls_idx;
   logic          cls_present;
   logic          cls_ambiguous;
   logic [NZ-1:0] cls_onehot;

   always_comb begin
      pop_count = 5'd0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         pop_count = pop_count + 5'(filt[i]);
      end
   end

   always_comb begin
      cls_idx     = '0;
      cls_present = 1'b0;
      if (pop_count == 5'd1) begin
         for (int i = 0; i < NUM_SENSORS; i++) begin
            if (filt[i]) begin
               cls_idx     = ZW'(2 * i);
               cls_present = 1'b1;
            end
         end
      end else if (pop_count == 5'd2) begin
         // Only a ring-adjacent pair is legal; (N-1, 0) is the wrap pair.
         for (int i = 0; i < NUM_SENSORS; i++) begin
            if (filt[i] && filt[(i + 1) % NUM_SENSORS]) begin
               cls_idx     = ZW'(2 * i + 1);
               cls_present = 1'b1;
            end
         end
      end
   end

   assign cls_ambiguous = (filt != '0) && !cls_present;
   assign cls_onehot    = cls_present ? (NZ'(1) << cls_idx) : '0;

   // ------------------------------------------------------------------
   // Registered zone outputs
   // ------------------------------------------------------------------
`ifdef OBJ_HOLD_EN
   logic [7:0] hold_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         zone_onehot  <= '0;
         zone_idx     <= '0;
         zone_present <= 1'b0;
         ambiguous    <= 1'b0;
         hold_count   <= 8'd0;
      end else if (cls_present || cls_ambiguous) begin
         zone_onehot  <= cls_onehot;
         zone_idx     <= cls_idx;
         zone_present <= cls_present;
         ambiguous    <= cls_ambiguous;
         hold_count   <= 8'd0;
      end else if (zone_present && (hold_count != 8'(HOLD_CYCLES))) begin
         // Pattern is empty but a zone was showing: keep it a while longer.
         hold_count <= hold_count + 8'd1;
      end else begin
         zone_onehot  <= '0;
         zone_idx     <= '0;
         zone_present <= 1'b0;
         ambiguous    <= 1'b0;
         hold_count   <= 8'd0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         zone_onehot  <= '0;
         zone_idx     <= '0;
         zone_present <= 1'b0;
         ambiguous    <= 1'b0;
      end else begin
         zone_onehot  <= cls_onehot;
         zone_idx     <= cls_idx;
         zone_present <= cls_present;
         ambiguous    <= cls_ambiguous;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Change detection: ambiguous alone never produces an event because
   // it is not part of the compared value.
   // ------------------------------------------------------------------
   logic [ZW-1:0] prev_idx;
   logic          prev_present;
   logic          zone_change;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_idx     <= '0;
         prev_present <= 1'b0;
      end else begin
         prev_idx     <= zone_idx;
         prev_present <= zone_present;
      end
   end

   assign zone_change = {zone_present, zone_idx} != {prev_present, prev_idx};

   // ------------------------------------------------------------------
   // Single-entry event register
   // ------------------------------------------------------------------
   evt_state_t evt_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         evt_state    <= EVT_IDLE;
         evt_valid    <= 1'b0;
         evt_zone_idx <= '0;
         evt_present  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (clr_overflow) begin
            overflow <= 1'b0;
         end
         case (evt_state)
            EVT_IDLE: begin
               if (zone_change) begin
                  evt_zone_idx <= zone_idx;
                  evt_present  <= zone_present;
                  evt_valid    <= 1'b1;
                  evt_state    <= EVT_PEND;
               end
            end
            EVT_PEND: begin
               if (zone_change) begin
                  // Accepted-and-replaced is clean; replaced unseen is lost.
                  evt_zone_idx <= zone_idx;
                  evt_present  <= zone_present;
                  if (!evt_ready) begin
                     overflow <= 1'b1;
                  end
               end else if (evt_ready) begin
                  evt_valid <= 1'b0;
                  evt_state <= EVT_IDLE;
               end
            end
            default: begin
               evt_valid <= 1'b0;
               evt_state <= EVT_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obj_zone_tracker.sv
module tb_obj_zone_tracker;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int H  = 8;
   localparam int ZW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  sensor_raw;
   logic [2*N-1:0] zone_onehot;
   logic [ZW-1:0] zone_idx;
   logic          zone_present;
   logic          ambiguous;
   logic          evt_valid;
   logic          evt_ready;
   logic [ZW-1:0] evt_zone_idx;
   logic          evt_present;
   logic          overflow;
   logic          clr_overflow;

   int vectors    = 0;
   int miscompares = 0;

   obj_zone_tracker #(
      .NUM_SENSORS    (N),
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sensor_raw  (sensor_raw),
      .zone_onehot (zone_onehot),
      .zone_idx    (zone_idx),
      .zone_present(zone_present),
      .ambiguous   (ambiguous),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_zone_idx(evt_zone_idx),
      .evt_present (evt_present),
      .overflow    (overflow),
      .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
   endtask

   initial begin
      reset        = 1'b1;
      sensor_raw   = '0;
      evt_ready    = 1'b0;
      clr_overflow = 1'b0;
      tick(3);
      reset = 1'b0;

      // Reset state
      check("rst_onehot",   32'(zone_onehot),  32'h0);
      check("rst_present",  32'(zone_present), 32'h0);
      check("rst_evt_valid",32'(evt_valid),    32'h0);
      check("rst_overflow", 32'(overflow),     32'h0);

      // 1: single front sensor, 7-edge latency to outputs, event one edge later
      sensor_raw = 4'b0001;
      tick(6);
      check("t1_early_present", 32'(zone_present), 32'h0);
      tick(1);
      check("t1_onehot",  32'(zone_onehot),  32'h01);
      check("t1_idx",     32'(zone_idx),     32'h0);
      check("t1_present", 32'(zone_present), 32'h1);
      check("t1_evt_not_yet", 32'(evt_valid), 32'h0);
      tick(1);
      check("t1_evt_valid",   32'(evt_valid),    32'h1);
      check("t1_evt_idx",     32'(evt_zone_idx), 32'h0);
      check("t1_evt_present", 32'(evt_present),  32'h1);
      evt_ready = 1'b1;
      tick(1);
      check("t1_evt_consumed", 32'(evt_valid), 32'h0);

      // 2: wrap pair 3/0 -> zone 7, then 0101 -> ambiguous with a lost event
      sensor_raw = 4'b1001;
      tick(7);
      check("t2_wrap_idx",    32'(zone_idx),    32'h7);
      check("t2_wrap_onehot", 32'(zone_onehot), 32'h80);
      tick(1);
      check("t2_evt_idx", 32'(evt_zone_idx), 32'h7);
      tick(1);
      sensor_raw = 4'b0101;
      tick(7);
      check("t2_ambiguous",  32'(ambiguous),    32'h1);
      check("t2_amb_present",32'(zone_present), 32'h0);
      check("t2_amb_onehot", 32'(zone_onehot),  32'h0);
      check("t2_amb_idx",    32'(zone_idx),     32'h0);
      tick(1);
      check("t2_evt_valid",   32'(evt_valid),   32'h1);
      check("t2_evt_present", 32'(evt_present), 32'h0);
      tick(1);

      // 3: leaving ambiguous to empty makes no event; glitch filtering
      sensor_raw = 4'b0000;
      tick(10);
      check("t3_amb_clear",    32'(ambiguous), 32'h0);
      check("t3_no_amb_event", 32'(evt_valid), 32'h0);
      sensor_raw = 4'b0100;
      tick(3);
      sensor_raw = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         check("t3_short_pulse_present", 32'(zone_present), 32'h0);
         check("t3_short_pulse_evt",     32'(evt_valid),    32'h0);
      end
      sensor_raw = 4'b0100;
      tick(4);
      sensor_raw = 4'b0000;
      tick(3);
      check("t3_pulse_idx",     32'(zone_idx),     32'h4);
      check("t3_pulse_present", 32'(zone_present), 32'h1);
      tick(30);
      check("t3_settled", 32'(zone_present), 32'h0);

      // 4: consumer stalled, second change overwrites the pending event
      evt_ready  = 1'b0;
      sensor_raw = 4'b0010;
      tick(8);
      check("t4_idx",       32'(zone_idx),     32'h2);
      check("t4_evt_idx",   32'(evt_zone_idx), 32'h2);
      check("t4_no_ovf",    32'(overflow),     32'h0);
      sensor_raw = 4'b0110;
      tick(7);
      check("t4_idx_pair",  32'(zone_idx),     32'h3);
      check("t4_evt_stable",32'(evt_zone_idx), 32'h2);
      tick(1);
      check("t4_evt_overwr",32'(evt_zone_idx), 32'h3);
      check("t4_overflow",  32'(overflow),     32'h1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check("t4_ovf_clear", 32'(overflow),     32'h0);
      check("t4_evt_held",  32'(evt_valid),    32'h1);
      check("t4_evt_held_idx", 32'(evt_zone_idx), 32'h3);

      // 5: accept and new change in the same cycle, then reset mid-PEND
      sensor_raw = 4'b0100;
      tick(7);
      check("t5_idx", 32'(zone_idx), 32'h4);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("t5_evt_valid", 32'(evt_valid),    32'h1);
      check("t5_evt_idx",   32'(evt_zone_idx), 32'h4);
      check("t5_no_ovf",    32'(overflow),     32'h0);
      sensor_raw = 4'b0000;
      reset      = 1'b1;
      evt_ready  = 1'b1;
      tick(1);
      check("t5_rst_present", 32'(zone_present), 32'h0);
      check("t5_rst_onehot",  32'(zone_onehot),  32'h0);
      check("t5_rst_evt",     32'(evt_valid),    32'h0);
      check("t5_rst_evt_idx", 32'(evt_zone_idx), 32'h0);
      reset = 1'b0;
      tick(12);

      // 6: loss of zone, with or without hold
      sensor_raw = 4'b0001;
      tick(12);
      check("t6_zone0", 32'(zone_present), 32'h1);
      sensor_raw = 4'b0000;
`ifdef OBJ_HOLD_EN
      tick(7);
      check("t6_hold_start", 32'(zone_present), 32'h1);
      tick(7);
      check("t6_hold_last",  32'(zone_present), 32'h1);
      tick(1);
      check("t6_hold_end",   32'(zone_present), 32'h0);
      tick(1);
      check("t6_lost_evt",   32'(evt_valid),   32'h1);
      check("t6_lost_pres",  32'(evt_present), 32'h0);
      sensor_raw = 4'b0001;
      tick(12);
      sensor_raw = 4'b0000;
      tick(7);
      sensor_raw = 4'b0100;
      tick(6);
      check("t6_cancel_pre_idx", 32'(zone_idx),     32'h0);
      check("t6_cancel_pre_pres",32'(zone_present), 32'h1);
      tick(1);
      check("t6_cancel_idx",     32'(zone_idx),     32'h4);
`else
      tick(6);
      check("t6_before_loss", 32'(zone_present), 32'h1);
      tick(1);
      check("t6_loss",        32'(zone_present), 32'h0);
      tick(1);
      check("t6_lost_evt",    32'(evt_valid),   32'h1);
      check("t6_lost_pres",   32'(evt_present), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
